// File: rtl/aes_spi_sequencer_if.sv
// Byte-transfer handshake between the AES block sequencer and an SPI master.
//   m_start    : one-cycle request to shift out m_data_in
//   m_buzy     : SPI master cannot accept a new request
//   m_done     : one-cycle pulse, transfer finished, m_data_out valid
//   m_data_in  : byte to transmit (held by the sequencer until m_done)
//   m_data_out : byte received from the slave
// Modport "master" is the sequencer side, "slave" is the SPI engine side.
interface aes_spi_sequencer_if;
    logic       m_start;
    logic       m_buzy;
    logic       m_done;
    logic [7:0] m_data_in;
    logic [7:0] m_data_out;

    modport master (
        output m_start,
        output m_data_in,
        input  m_buzy,
        input  m_done,
        input  m_data_out
    );

    modport slave (
        input  m_start,
        input  m_data_in,
        output m_buzy,
        output m_done,
        output m_data_out
    );
endinterface

// File: rtl/aes_spi_sequencer.sv
// Streams one AES block operation over a byte-wide SPI master:
// 16 plaintext bytes (MSB first), one key-length byte, N key bytes
// (most significant first), then 16 dummy transfers whose received
// bytes form the result block.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   go                  : one-cycle start request (ignored while busy)
//   key_size_sel [1:0]  : 00=128, 01=192, 10=256, 11=invalid (-> error)
//   text_in [127:0]     : input block, byte 15 = [127:120]
//   key_in [255:0]      : right-aligned key
//   result [127:0]      : received block, valid with result_valid
//   result_valid        : one-cycle completion pulse
//   busy                : operation in progress
//   error               : sticky fault flag, cleared by the next accepted go
//   spi                 : SPI master handshake (master modport)
module aes_spi_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       go,
    input  logic [1:0]                 key_size_sel,
    input  logic [127:0]               text_in,
    input  logic [255:0]               key_in,
    output logic [127:0]               result,
    output logic                       result_valid,
    output logic                       busy,
    output logic                       error,
    aes_spi_sequencer_if.master        spi
);
    // +2 keeps the widths at least one bit even for a zero-length gap
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_DONE, S_GAP, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {PH_PT, PH_KS, PH_KEY, PH_RX} phase_t;

    state_t        state_reg;
    phase_t        phase_reg;
    logic [6:0]    cnt_reg;      // bytes still to send in the current phase
    logic [TW-1:0] wd_reg;
    logic [GW-1:0] gap_reg;
    logic [127:0]  text_reg;
    logic [255:0]  key_reg;
    logic [1:0]    sel_reg;

    logic [7:0]    text_byte [16];
    logic [7:0]    key_byte  [32];
    logic [4:0]    byte_idx;
    logic [6:0]    key_len;
    logic [7:0]    tx_byte;
    logic          last_byte;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_text
            assign text_byte[gi] = text_reg[gi*8 +: 8];
        end
        for (gi = 0; gi < 32; gi++) begin : g_key
            assign key_byte[gi] = key_reg[gi*8 +: 8];
        end
    endgenerate

    // The counter runs N..1, so the byte number inside the phase is cnt-1.
    // This gives MSB-first order for text and key, and the RX slot
    // (15 - rx_index) for the received bytes.
    assign byte_idx  = 5'(cnt_reg - 7'd1);
    assign last_byte = (phase_reg == PH_RX) && (cnt_reg == 7'd1);

    always_comb begin
        key_len = 7'd16;
        case (sel_reg)
            2'b01:   key_len = 7'd24;
            2'b10:   key_len = 7'd32;
            default: key_len = 7'd16;
        endcase
    end

    // The key-length byte equals the key length in bytes (0x10/0x18/0x20).
    always_comb begin
        tx_byte = 8'h00;
        case (phase_reg)
            PH_PT:   tx_byte = text_byte[byte_idx[3:0]];
            PH_KS:   tx_byte = {1'b0, key_len};
            PH_KEY:  tx_byte = key_byte[byte_idx];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            phase_reg     <= PH_PT;
            cnt_reg       <= '0;
            wd_reg        <= '0;
            gap_reg       <= '0;
            text_reg      <= '0;
            key_reg       <= '0;
            sel_reg       <= '0;
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            spi.m_start   <= 1'b0;
            spi.m_data_in <= 8'h00;
        end else begin
            spi.m_start  <= 1'b0;
            result_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        if (key_size_sel == 2'b11) begin
                            error     <= 1'b1;
                            state_reg <= S_ERROR;
                        end else begin
                            // operands captured at acceptance so later input
                            // changes cannot leak into the running block
                            text_reg  <= text_in;
                            key_reg   <= key_in;
                            sel_reg   <= key_size_sel;
                            error     <= 1'b0;
                            result    <= '0;
                            busy      <= 1'b1;
                            state_reg <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    phase_reg <= PH_PT;
                    cnt_reg   <= 7'd16;
                    state_reg <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!spi.m_buzy) begin
                        spi.m_start   <= 1'b1;
                        spi.m_data_in <= tx_byte;
                        wd_reg        <= '0;
                        state_reg     <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // m_done wins over a watchdog expiry in the same cycle
                    if (spi.m_done) begin
                        if (phase_reg == PH_RX)
                            result[{byte_idx[3:0], 3'b000} +: 8] <= spi.m_data_out;
                        if (cnt_reg != 7'd1) begin
                            cnt_reg <= cnt_reg - 7'd1;
                        end else begin
                            case (phase_reg)
                                PH_PT:  begin phase_reg <= PH_KS;  cnt_reg <= 7'd1;   end
                                PH_KS:  begin phase_reg <= PH_KEY; cnt_reg <= key_len; end
                                PH_KEY: begin phase_reg <= PH_RX;  cnt_reg <= 7'd16;  end
                                default: cnt_reg <= 7'd0;
                            endcase
                        end
                        if (last_byte) begin
                            state_reg <= S_DONE;
                        end else if (GAP_CYCLES == 0) begin
                            state_reg <= S_ISSUE;
                        end else begin
                            gap_reg   <= '0;
                            state_reg <= S_GAP;
                        end
                    end else if (wd_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= S_ERROR;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_reg == GW'(GAP_CYCLES - 1))
                        state_reg <= S_ISSUE;
                    else
                        gap_reg <= gap_reg + 1'b1;
                end
                S_DONE: begin
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state_reg    <= S_IDLE;
                end
                S_ERROR: begin
                    error     <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Directed bench for aes_spi_sequencer: a behavioural SPI slave logs every
// transmitted byte, answers after a fixed latency and returns a chosen
// block in the RX phase; the main sequence runs the block scenarios.
module tb_aes_spi_sequencer;
    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [1:0]   key_size_sel;
    logic [127:0] text_in;
    logic [255:0] key_in;
    logic [127:0] result;
    logic         result_valid;
    logic         busy;
    logic         error;

    aes_spi_sequencer_if spi_if();

    aes_spi_sequencer #(
        .TIMEOUT_CYCLES(16),
        .GAP_CYCLES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .key_size_sel (key_size_sel),
        .text_in      (text_in),
        .key_in       (key_in),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .error        (error),
        .spi          (spi_if)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] TEXT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_192 = {64'h0, 192'h000102030405060708090a0b0c0d0e0f1011121314151617};
    localparam logic [255:0] KEY_128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [127:0] RX_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] RX_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RX_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    int cmp_count = 0;
    int fail_count = 0;
    int cyc = 0;
    int rv_total = 0;

    // written by the slave only
    int tx_total = 0;
    int hold_errs = 0;
    logic [7:0] tx_log [128];
    int gap_log [128];

    // written by the main sequence only
    int run_base = 0;
    int rx_first = 200;
    int stall_at = -1;
    bit respond = 1'b1;
    logic [127:0] rx_blk = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (result_valid) rv_total <= rv_total + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        cmp_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // SPI slave: 3-cycle latency, optional 5-cycle m_buzy stall after a
    // chosen transfer, checks that m_data_in is held and m_start not repeated.
    initial begin : slave
        int k;
        int last_done;
        bit abort;
        logic [7:0] b;
        spi_if.m_buzy     = 1'b0;
        spi_if.m_done     = 1'b0;
        spi_if.m_data_out = 8'h00;
        last_done = 0;
        forever begin
            @(posedge clk); #1;
            if (spi_if.m_start && !reset) begin
                b = spi_if.m_data_in;
                k = tx_total - run_base;
                tx_total++;
                if (k >= 0 && k < 128) begin
                    tx_log[k]  = b;
                    gap_log[k] = cyc - last_done;
                end
                if (respond) begin
                    abort = 1'b0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        if (reset) abort = 1'b1;
                        if (!abort && (spi_if.m_data_in !== b || spi_if.m_start)) hold_errs++;
                    end
                    if (k >= rx_first && k < rx_first + 16)
                        spi_if.m_data_out = rx_blk[127 - 8*(k - rx_first) -: 8];
                    else
                        spi_if.m_data_out = 8'h5a;
                    spi_if.m_done = 1'b1;
                    last_done = cyc;
                    @(posedge clk); #1;
                    spi_if.m_done = 1'b0;
                    if (k == stall_at) begin
                        repeat (2) @(posedge clk);
                        #1;
                        spi_if.m_buzy = 1'b1;
                        repeat (5) @(posedge clk);
                        #1;
                        spi_if.m_buzy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic pulse_go(input logic [127:0] t, input logic [255:0] k, input logic [1:0] s);
        text_in      = t;
        key_in       = k;
        key_size_sel = s;
        go           = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic run_block(input string name, input logic [127:0] txt, input logic [255:0] key,
                             input logic [1:0] sel, input int n, input int exp_total,
                             input logic [127:0] rx, input int stall, input bit mid_go);
        int base;
        int rv_base;
        int seq_errs;
        bit seen;
        logic [7:0] e;
        base     = tx_total;
        run_base = base;
        rx_first = 17 + n;
        rx_blk   = rx;
        stall_at = stall;
        rv_base  = rv_total;
        pulse_go(txt, key, sel);
        check({name, ".busy_load"}, busy, 1);
        check({name, ".err_clear"}, error, 0);
        if (mid_go) begin
            repeat (30) @(posedge clk);
            #1;
            pulse_go(~txt, ~key, 2'b00);
        end
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, ".done_seen"}, seen, 1);
        check({name, ".result"}, result, rx);
        repeat (3) @(posedge clk);
        #1;
        check({name, ".busy_idle"}, busy, 0);
        check({name, ".rv_pulses"}, rv_total - rv_base, 1);
        check({name, ".transfers"}, tx_total - base, exp_total);
        check({name, ".ks_byte"}, tx_log[16], n);
        check({name, ".key_first"}, tx_log[17], 8'h00);
        check({name, ".key_last"}, tx_log[16 + n], n - 1);
        seq_errs = 0;
        for (int i = 0; i < exp_total; i++) begin
            if (i < 16)          e = txt[127 - 8*i -: 8];
            else if (i == 16)    e = 8'(n);
            else if (i < 17 + n) e = key[8*n - 1 - 8*(i - 17) -: 8];
            else                 e = 8'h00;
            if (tx_log[i] !== e) seq_errs++;
        end
        check({name, ".tx_sequence"}, seq_errs, 0);
        check({name, ".gap_normal"}, gap_log[5], 4);
        if (stall >= 0) check({name, ".gap_stalled"}, gap_log[stall + 1], 9);
        check({name, ".data_hold"}, hold_errs, 0);
        $display("run %s: %0d transfers, result %h", name, tx_total - base, result);
    endtask

    initial begin : main
        int base;
        int t0;
        int t1;
        bit seen;
        bit err_seen;
        bit busy_seen;
        reset        = 1'b1;
        go           = 1'b0;
        key_size_sel = 2'b00;
        text_in      = '0;
        key_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("init.result", result, 0);
        check("init.result_valid", result_valid, 0);
        check("init.busy", busy, 0);
        check("init.error", error, 0);
        check("init.m_start", spi_if.m_start, 0);
        check("init.m_data_in", spi_if.m_data_in, 0);

        run_block("k256", TEXT_A, KEY_256, 2'b10, 32, 65, RX_256, -1, 1'b0);
        run_block("k128_stall_go", TEXT_A, KEY_128, 2'b00, 16, 49, RX_128, 2, 1'b1);

        // invalid key size
        base = tx_total;
        pulse_go(TEXT_A, KEY_256, 2'b11);
        err_seen  = error;
        busy_seen = busy;
        @(posedge clk); #1;
        err_seen  = err_seen | error;
        busy_seen = busy_seen | busy;
        repeat (10) begin
            @(posedge clk); #1;
            busy_seen = busy_seen | busy;
        end
        check("sel11.error", err_seen, 1);
        check("sel11.busy", busy_seen, 0);
        check("sel11.no_start", tx_total - base, 0);
        $display("run sel11: error=%0b", error);

        run_block("k128_after_err", ~TEXT_A, KEY_128, 2'b00, 16, 49, RX_128, -1, 1'b0);

        // silent slave -> watchdog
        respond  = 1'b0;
        run_base = tx_total;
        base     = tx_total;
        t0 = 0;
        t1 = 0;
        pulse_go(TEXT_A, KEY_128, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (spi_if.m_start) begin
                t0 = cyc;
                seen = 1'b1;
                break;
            end
        end
        check("to.start_seen", seen, 1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (error) begin
                t1 = cyc;
                seen = 1'b1;
                break;
            end
        end
        check("to.error_seen", seen, 1);
        check("to.latency", t1 - t0, 16);
        check("to.busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("to.one_start", tx_total - base, 1);
        check("to.error_sticky", error, 1);
        $display("run timeout: latency %0d cycles", t1 - t0);
        respond = 1'b1;

        run_block("k192_after_to", TEXT_A, KEY_192, 2'b01, 24, 57, RX_192, -1, 1'b0);

        // reset in the KEY phase
        run_base = tx_total;
        rx_first = 33;
        rx_blk   = RX_128;
        stall_at = -1;
        pulse_go(TEXT_A, KEY_128, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (tx_total - run_base >= 20) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst.key_phase", seen, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst.result", result, 0);
        check("rst.result_valid", result_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.error", error, 0);
        check("rst.m_start", spi_if.m_start, 0);
        check("rst.m_data_in", spi_if.m_data_in, 0);
        reset = 1'b0;
        base = tx_total;
        repeat (20) @(posedge clk);
        #1;
        check("rst.no_start", tx_total - base, 0);
        $display("run reset_in_key: aborted after %0d transfers", base - run_base);

        run_block("k256_after_rst", TEXT_A, KEY_256, 2'b10, 32, 65, RX_256, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/aes_spi_sequencer.md
AES_SPI_SEQUENCER -- requirements
Module: aes_spi_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles from m_start to m_done before the transfer is aborted.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles between m_done and the next m_start.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 go  input  1  one-cycle request to start a block operation.
REQ-006 key_size_sel  input  2  key size: 00=128, 01=192, 10=256, 11=invalid.
REQ-007 text_in  input  128  input block, byte 15 = bits [127:120].
REQ-008 key_in  input  256  right-aligned key; an N-byte key occupies [N*8-1:0].
REQ-009 result  output  128  received block, byte 15 = bits [127:120].
REQ-010 result_valid  output  1  one-cycle pulse when result is complete.
REQ-011 busy  output  1  high from go acceptance until DONE or ERROR is left.
REQ-012 error  output  1  sticky fault flag, cleared by the next accepted go.
REQ-013 m_start  output  1  one-cycle byte-transfer request to the SPI master.
REQ-014 m_buzy  input  1  SPI master busy.
REQ-015 m_done  input  1  SPI master byte-complete pulse.
REQ-016 m_data_in  output  8  byte to transmit.
REQ-017 m_data_out  input  8  byte received, valid in the m_done cycle.

Function
REQ-018 States: IDLE, LOAD, ISSUE, WAIT_DONE, GAP, DONE, ERROR.
REQ-019 Phases, in order:
- PT: 16 bytes of text_in, MSB first.
- KS: 1 byte, the key length value 0x10, 0x18 or 0x20.
- KEY: N bytes, key_in[N*8-1 -: 8] down to byte 0.
- RX: 16 transfers with m_data_in = 0x00.
REQ-020 IDLE: go=1 moves to LOAD.
- LOAD actions: latch text_in, key_in and key_size_sel; clear error and result; set busy.
REQ-021 IDLE with go=1 and key_size_sel=11 moves to ERROR instead; no m_start is issued.
REQ-022 LOAD moves to ISSUE on the next cycle.
REQ-023 ISSUE with m_buzy=0: assert m_start for exactly one cycle with m_data_in valid, then move to WAIT_DONE.
REQ-024 ISSUE with m_buzy=1: stall in ISSUE with m_start=0.
REQ-025 m_data_in holds its value from the m_start cycle until m_done.
REQ-026 WAIT_DONE with m_done=1:
- In RX, capture m_data_out into result byte (15 - rx_index).
- Decrement the byte counter.
- Move to GAP, or to DONE if it was the last RX byte.
REQ-027 GAP lasts exactly GAP_CYCLES cycles, then returns to ISSUE; GAP_CYCLES=0 goes straight to ISSUE.
REQ-028 WAIT_DONE watchdog: resets on each m_start and counts every WAIT_DONE cycle.
- Reaching TIMEOUT_CYCLES without m_done moves to ERROR.
- m_done in the same cycle as the count reaches TIMEOUT_CYCLES takes priority (byte accepted).
REQ-029 DONE: pulse result_valid for 1 cycle, then IDLE with busy=0; result holds until the next LOAD.
REQ-030 ERROR: set error=1, busy=0, m_start=0, then IDLE.
REQ-031 go while busy=1 is ignored; latched operands do not change.
REQ-032 m_done outside WAIT_DONE is ignored.
REQ-033 Total transfers per block: 49 (128-bit key), 57 (192-bit), 65 (256-bit).
REQ-034 Byte counter is 7 bits wide; the phase changes when the counter reaches 0 within a phase, with no wrap.

Reset
REQ-035 Reset returns to IDLE, dominates go, and takes effect mid-transfer with no further m_start.
REQ-036 Reset values: result=0, result_valid=0, busy=0, error=0, m_start=0, m_data_in=0x00, counters=0.

Verification
REQ-037 256-bit run:
- Stimulus: text 00112233445566778899aabbccddeeff, key 000102..1f, sel=10; slave model returns 8ea2b7ca516745bfeafc49904b496089.
- Required: 65 m_start pulses, 17th byte 0x20, result matches the returned block, one result_valid pulse.
REQ-038 128-bit run:
- Stimulus: key 000102..0f in key_in[127:0], sel=00; slave returns 69c4e0d86a7b0430d8cdb78070b4c55a.
- Required: 49 transfers, 17th byte 0x10, first key byte 0x00, result equals the returned block.
REQ-039 sel=11 with go -> error=1 within 2 cycles, zero m_start pulses, busy stays 0.
REQ-040 Slave never returns m_done (TIMEOUT_CYCLES=16):
- First transfer -> error=1 exactly 16 cycles after m_start, then IDLE.
- Next go clears error.
REQ-041 Reset asserted during KEY phase -> all outputs at reset values the next cycle; a subsequent normal run completes correctly.
REQ-042 Timing corner cases:
- go pulsed mid-operation -> ignored; transfer count unchanged.
- m_buzy held high for 5 cycles in ISSUE -> m_start is delayed 5 cycles, not dropped or duplicated.
